// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: symbol modes, fixed control/guard codes, the TERC4
// table and a population-count helper used by the lane encoder.
package tmds_pkg;

    typedef enum logic [1:0] {
        MODE_CTRL  = 2'd0,
        MODE_VIDEO = 2'd1,
        MODE_TERC4 = 2'd2,
        MODE_GUARD = 2'd3
    } mode_e;

    localparam logic [9:0] CTRL_00    = 10'b1101010100;
    localparam logic [9:0] CTRL_01    = 10'b0010101011;
    localparam logic [9:0] CTRL_10    = 10'b0101010100;
    localparam logic [9:0] CTRL_11    = 10'b1010101011;
    localparam logic [9:0] GUARD_EVEN = 10'b1011001100;
    localparam logic [9:0] GUARD_ODD  = 10'b0100110011;

    function automatic logic [9:0] ctrl_code(input logic [1:0] c);
        logic [9:0] code;
        case (c)
            2'b00:   code = CTRL_00;
            2'b01:   code = CTRL_01;
            2'b10:   code = CTRL_10;
            default: code = CTRL_11;
        endcase
        return code;
    endfunction

    function automatic logic [9:0] terc4_code(input logic [3:0] a);
        logic [9:0] code;
        case (a)
            4'd0:    code = 10'b1010011100;
            4'd1:    code = 10'b1001100011;
            4'd2:    code = 10'b1011100100;
            4'd3:    code = 10'b1011100010;
            4'd4:    code = 10'b0101110001;
            4'd5:    code = 10'b0100011110;
            4'd6:    code = 10'b0110001110;
            4'd7:    code = 10'b0100111100;
            4'd8:    code = 10'b1011001100;
            4'd9:    code = 10'b0100111001;
            4'd10:   code = 10'b0110011100;
            4'd11:   code = 10'b1011000110;
            4'd12:   code = 10'b1010001110;
            4'd13:   code = 10'b1001110001;
            4'd14:   code = 10'b0101100011;
            default: code = 10'b1011000011;
        endcase
        return code;
    endfunction

    function automatic logic [3:0] ones(input logic [9:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_lane.sv
// One TMDS channel: stage 1 does transition minimisation, stage 2 picks the
// symbol for the carried mode and keeps this lane's running disparity.
module tmds_lane
    import tmds_pkg::*;
#(
    parameter int CW       = 5,
    parameter bit ODD_LANE = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic [1:0] mode,
    input  logic [7:0] din,
    input  logic [1:0] ctrl,
    input  logic [3:0] aux,
    output logic [9:0] dout
);

    logic [3:0]           n1;
    logic                 use_xnor;
    logic                 chain;
    logic [8:0]           q_m;

    logic [8:0]           s1_qm;
    mode_e                s1_mode;
    logic [1:0]           s1_ctrl;
    logic [3:0]           s1_aux;

    logic signed [CW-1:0] cnt;
    logic signed [CW-1:0] cnt_next;
    logic [3:0]           m1;
    logic                 inv;
    logic [9:0]           video_sym;
    logic [3:0]           video_ones;
    logic [9:0]           sym;

    assign n1 = ones({2'b00, din});

    always_comb begin
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !din[0]);
        q_m      = '0;
        chain    = din[0];
        q_m[0]   = chain;
        for (int i = 1; i < 8; i++) begin
            chain  = use_xnor ? ~(chain ^ din[i]) : (chain ^ din[i]);
            q_m[i] = chain;
        end
        q_m[8] = ~use_xnor;
    end

    // Mode and side-band data travel with q_m so a mode switch lands on an exact symbol boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_qm   <= '0;
            s1_mode <= MODE_CTRL;
            s1_ctrl <= 2'b00;
            s1_aux  <= '0;
        end else if (ce) begin
            s1_qm   <= q_m;
            s1_mode <= mode_e'(mode);
            s1_ctrl <= ctrl;
            s1_aux  <= aux;
        end
    end

    assign m1 = ones({2'b00, s1_qm[7:0]});

    always_comb begin
        inv = 1'b0;
        if ((cnt == '0) || (m1 == 4'd4)) begin
            inv = ~s1_qm[8];
        end else begin
            inv = (!cnt[CW-1] && (m1 > 4'd4)) || (cnt[CW-1] && (m1 < 4'd4));
        end
        video_sym  = {inv, s1_qm[8], inv ? ~s1_qm[7:0] : s1_qm[7:0]};
        video_ones = ones(video_sym);
        cnt_next   = cnt + CW'(video_ones) - CW'(4'd5);
    end

    always_comb begin
        sym = CTRL_00;
        case (s1_mode)
            MODE_CTRL:  sym = ctrl_code(s1_ctrl);
            MODE_VIDEO: sym = video_sym;
            MODE_TERC4: sym = terc4_code(s1_aux);
            MODE_GUARD: sym = ODD_LANE ? GUARD_ODD : GUARD_EVEN;
            default:    sym = CTRL_00;
        endcase
    end

    // Any non-video symbol restarts the disparity tally from zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout <= CTRL_00;
            cnt  <= '0;
        end else if (ce) begin
            dout <= sym;
            cnt  <= (s1_mode == MODE_VIDEO) ? cnt_next : '0;
        end
    end

endmodule

// File: rtl/tmds_multi_encoder.sv
// NCH independent TMDS lanes sharing one mode; the top only slices buses and
// tracks whether dout holds a freshly produced symbol set.
module tmds_multi_encoder #(
    parameter int NCH = 3,
    parameter int CW  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic [1:0]        mode,
    input  logic [NCH*8-1:0]  din,
    input  logic [NCH*2-1:0]  ctrl,
    input  logic [NCH*4-1:0]  aux,
    output logic [NCH*10-1:0] dout,
    output logic              dout_valid
);

    logic s1_valid;

    genvar k;
    generate
        for (k = 0; k < NCH; k++) begin : g_lane
            tmds_lane #(
                .CW       (CW),
                .ODD_LANE (1'(k % 2))
            ) u_lane (
                .clk   (clk),
                .reset (reset),
                .ce    (ce),
                .mode  (mode),
                .din   (din[8*k +: 8]),
                .ctrl  (ctrl[2*k +: 2]),
                .aux   (aux[4*k +: 4]),
                .dout  (dout[10*k +: 10])
            );
        end
    endgenerate

    // Stage 1 holds real data once any ce has loaded it; dout is new only on a ce edge after that.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= ce & s1_valid;
            if (ce) begin
                s1_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tmds_multi_encoder.sv
// Directed and model-checked stimulus for the three-lane TMDS encoder.
module tb_tmds_multi_encoder;

    localparam logic [9:0] C00 = 10'b1101010100;
    localparam logic [9:0] C01 = 10'b0010101011;
    localparam logic [9:0] C10 = 10'b0101010100;
    localparam logic [9:0] C11 = 10'b1010101011;
    localparam logic [9:0] T0  = 10'b1010011100;
    localparam logic [9:0] T5  = 10'b0100011110;
    localparam logic [9:0] T15 = 10'b1011000011;
    localparam logic [9:0] GE  = 10'b1011001100;
    localparam logic [9:0] GO  = 10'b0100110011;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic [1:0]  mode;
    logic [23:0] din;
    logic [5:0]  ctrl;
    logic [11:0] aux;
    logic [29:0] dout;
    logic        dout_valid;

    int vectors = 0;
    int miscompares = 0;

    tmds_multi_encoder #(.NCH(3), .CW(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .mode       (mode),
        .din        (din),
        .ctrl       (ctrl),
        .aux        (aux),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] cw_bits(input int c);
        logic [31:0] v;
        v = c;
        return v[4:0];
    endfunction

    task automatic ref_video(input logic [7:0] d, input int cin, output logic [9:0] sym, output int cout);
        int         n1;
        int         m1;
        bit         xn;
        bit         inv;
        logic [8:0] q;
        n1 = $countones(d);
        xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = xn ? (q[i-1] == d[i]) : (q[i-1] != d[i]);
        q[8] = !xn;
        m1 = $countones(q[7:0]);
        if (cin == 0 || m1 == 4) inv = !q[8];
        else inv = (cin > 0 && m1 > 4) || (cin < 0 && m1 < 4);
        sym  = {inv, q[8], inv ? ~q[7:0] : q[7:0]};
        cout = cin + $countones(sym) - 5;
    endtask

    logic [7:0]  s1_byte [3];
    int          mcnt [3];
    bit          s1_video;
    bit          s1_valid;
    logic [29:0] exp_dout;
    logic        exp_valid;
    logic [9:0]  sym;
    int          nc;
    logic [31:0] r;
    bit          ce_v;

    initial begin
        reset = 1'b1; ce = 1'b0; mode = 2'd0; din = '0; ctrl = '0; aux = '0;
        tick(); tick();
        check("reset_dout", {2'b0, dout}, {2'b0, C00, C00, C00});
        check("reset_valid", {31'b0, dout_valid}, 32'd0);
        check("reset_cnt", {27'b0, dut.g_lane[0].u_lane.cnt}, 32'd0);

        ce = 1'b1; mode = 2'd1; din = 24'hFFFFFF;
        tick();
        check("reset_ce_dout", {2'b0, dout}, {2'b0, C00, C00, C00});
        check("reset_ce_valid", {31'b0, dout_valid}, 32'd0);

        reset = 1'b0; mode = 2'd0; ctrl = 6'b000000;
        tick();
        check("first_ce_valid", {31'b0, dout_valid}, 32'd0);
        tick();
        check("ctrl00_dout", {2'b0, dout}, {2'b0, C00, C00, C00});
        check("ctrl00_valid", {31'b0, dout_valid}, 32'd1);

        ctrl = 6'b11_10_01;
        tick(); tick();
        check("ctrl_mix", {2'b0, dout}, {2'b0, C11, C10, C01});

        mode = 2'd1; din = 24'h000000;
        tick(); tick();
        check("vid00_a", {2'b0, dout}, {2'b0, {3{10'b0100000000}}});
        check("vid00_a_cnt", {27'b0, dut.g_lane[0].u_lane.cnt}, {27'b0, 5'b11100});
        tick();
        check("vid00_b", {2'b0, dout}, {2'b0, {3{10'b1111111111}}});
        check("vid00_b_cnt", {27'b0, dut.g_lane[0].u_lane.cnt}, {27'b0, 5'b00001});
        mode = 2'd0; ctrl = 6'b0;
        tick();
        check("vid00_c", {2'b0, dout}, {2'b0, {3{10'b0100000000}}});
        check("vid00_c_cnt", {27'b0, dut.g_lane[0].u_lane.cnt}, {27'b0, 5'b11101});
        tick();
        check("ctrl_after_vid", {2'b0, dout}, {2'b0, C00, C00, C00});
        check("ctrl_clears_cnt", {27'b0, dut.g_lane[0].u_lane.cnt}, 32'd0);

        mode = 2'd1; din = 24'h55FF00;
        tick(); tick();
        check("vid_mix_a", {2'b0, dout}, {2'b0, 10'b0100110011, 10'b1000000000, 10'b0100000000});
        tick();
        check("vid_mix_b", {2'b0, dout}, {2'b0, 10'b0100110011, 10'b0011111111, 10'b1111111111});

        ce = 1'b0; din = 24'h123456; mode = 2'd3;
        tick(); tick();
        check("freeze_dout", {2'b0, dout}, {2'b0, 10'b0100110011, 10'b0011111111, 10'b1111111111});
        check("freeze_valid", {31'b0, dout_valid}, 32'd0);
        check("freeze_cnt", {27'b0, dut.g_lane[0].u_lane.cnt}, {27'b0, 5'b00001});

        ce = 1'b1; mode = 2'd2; aux = 12'h000;
        tick();
        check("vid_mix_c", {2'b0, dout}, {2'b0, 10'b0100110011, 10'b0011111111, 10'b0100000000});
        check("resume_valid", {31'b0, dout_valid}, 32'd1);
        aux = 12'hF5F;
        tick();
        check("terc4_0", {2'b0, dout}, {2'b0, T0, T0, T0});
        mode = 2'd3;
        tick();
        check("terc4_f5f", {2'b0, dout}, {2'b0, T15, T5, T15});
        check("terc4_cnt", {27'b0, dut.g_lane[0].u_lane.cnt}, 32'd0);
        mode = 2'd1; din = 24'h000000;
        tick();
        check("guard", {2'b0, dout}, {2'b0, GE, GO, GE});
        tick();
        check("vid_after_guard", {2'b0, dout}, {2'b0, {3{10'b0100000000}}});
        check("vid_after_guard_cnt", {27'b0, dut.g_lane[0].u_lane.cnt}, {27'b0, 5'b11100});

        reset = 1'b1; ce = 1'b1;
        tick();
        check("midreset_dout", {2'b0, dout}, {2'b0, C00, C00, C00});
        check("midreset_valid", {31'b0, dout_valid}, 32'd0);
        check("midreset_cnt", {27'b0, dut.g_lane[0].u_lane.cnt}, 32'd0);
        reset = 1'b0;

        s1_video = 1'b0; s1_valid = 1'b0;
        exp_dout = {C00, C00, C00};
        for (int k = 0; k < 3; k++) begin
            mcnt[k] = 0;
            s1_byte[k] = 8'h00;
        end
        for (int i = 0; i < 1500; i++) begin
            r    = $urandom;
            ce_v = ($urandom_range(0, 3) != 0);
            ce   = ce_v;
            mode = 2'd1;
            din  = r[23:0];
            tick();
            if (ce_v) begin
                for (int k = 0; k < 3; k++) begin
                    if (s1_video) begin
                        ref_video(s1_byte[k], mcnt[k], sym, nc);
                        mcnt[k] = nc;
                    end else begin
                        sym = C00;
                        mcnt[k] = 0;
                    end
                    exp_dout[k*10 +: 10] = sym;
                    s1_byte[k] = r[k*8 +: 8];
                end
                s1_video  = 1'b1;
                exp_valid = s1_valid;
                s1_valid  = 1'b1;
            end else begin
                exp_valid = 1'b0;
            end
            check("rand_dout", {2'b0, dout}, {2'b0, exp_dout});
            check("rand_valid", {31'b0, dout_valid}, {31'b0, exp_valid});
            check("rand_cnt", {27'b0, dut.g_lane[0].u_lane.cnt}, {27'b0, cw_bits(mcnt[0])});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
